bram_sdp_banked: RTL and testbench

Multi-bank simple-dual-port block RAM for the DRNN datapath. It has one write port and one read port, each with its own bank select. Writes support per-byte enables, and read-during-write behaviour is selectable. Read latency is 1 or 2 cycles and is tracked by a valid pipeline. After reset, an optional sweep zeroes every bank before the first access is accepted. It replaces flat single-bank buffers wherever several channels or layers need to share one storage instance.

---
 rtl/bram_sdp_banked_if.sv | 29 ++
 rtl/bram_sdp_banked.sv | 187 ++++++++++++++++++
 tb/tb_bram_sdp_banked.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_sdp_banked_if.sv
// Port bundle for bram_sdp_banked: write request, read request, read response and init status.
interface bram_sdp_banked_if #(
  parameter int DATA_BIT_WIDTH  = 32,
  parameter int DEPTH_BIT_WIDTH = 9,
  parameter int BANK_W          = 2
);
  logic                             cs;
  logic                             wr_en;
  logic [BANK_W-1:0]                wr_bank;
  logic [DEPTH_BIT_WIDTH-1:0]       addr_wr;
  logic [DATA_BIT_WIDTH/8-1:0]      wr_be;
  logic signed [DATA_BIT_WIDTH-1:0] din;
  logic                             rd_en;
  logic [BANK_W-1:0]                rd_bank;
  logic [DEPTH_BIT_WIDTH-1:0]       addr_rd;
  logic signed [DATA_BIT_WIDTH-1:0] dout;
  logic                             dout_valid;
  logic                             init_busy;

  modport master (
    output cs, wr_en, wr_bank, addr_wr, wr_be, din, rd_en, rd_bank, addr_rd,
    input  dout, dout_valid, init_busy
  );

  modport slave (
    input  cs, wr_en, wr_bank, addr_wr, wr_be, din, rd_en, rd_bank, addr_rd,
    output dout, dout_valid, init_busy
  );
endinterface

// File: rtl/bram_sdp_banked.sv
// Banked simple-dual-port RAM with byte enables, selectable read-during-write,
// 1/2-cycle read latency and an optional post-reset zeroing sweep.
module bram_sdp_bank #(
  parameter int DW = 32,
  parameter int AW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [DW/8-1:0] wbe,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // The registered read samples the pre-write word, giving read-first behaviour.
  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

module bram_sdp_banked #(
  parameter int DATA_BIT_WIDTH  = 32,
  parameter int DEPTH_BIT_WIDTH = 9,
  parameter int NUM_BANKS       = 4,
  parameter int RD_LATENCY      = 1,
  parameter int RDW_MODE        = 0,
  parameter int CLEAR_ON_RESET  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_sdp_banked_if.slave bus
);
  localparam int DW     = DATA_BIT_WIDTH;
  localparam int AW     = DEPTH_BIT_WIDTH;
  localparam int BE_W   = DW / 8;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic busy, wr_acc, rd_acc, coll;
  logic [BANK_W-1:0] wb_e, rb_e;

  assign busy   = (state_q == CLEAR);
  assign wr_acc = bus.cs & bus.wr_en & ~busy;
  assign rd_acc = bus.cs & bus.rd_en & ~busy;
  assign wb_e   = (NUM_BANKS == 1) ? '0 : bus.wr_bank;
  assign rb_e   = (NUM_BANKS == 1) ? '0 : bus.rd_bank;
  assign coll   = rd_acc & wr_acc & (wb_e == rb_e) & (bus.addr_wr == bus.addr_rd);
  assign bus.init_busy = busy;

  // During the sweep the write port is borrowed to zero the same address in every bank.
  logic [BE_W-1:0] wbe_m;
  logic [AW-1:0]   waddr_m;
  logic [DW-1:0]   wdata_m;

  always_comb begin
    wbe_m   = busy ? '1    : bus.wr_be;
    waddr_m = busy ? cnt_q : bus.addr_wr;
    wdata_m = busy ? '0    : bus.din;
  end

  logic [NUM_BANKS-1:0]         bk_we, bk_re;
  logic [NUM_BANKS-1:0][DW-1:0] bk_rdata;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bk_we[b] = busy | (wr_acc & (wb_e == BANK_W'(b)));
    assign bk_re[b] = rd_acc & (rb_e == BANK_W'(b));

    bram_sdp_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bk_we[b]),
      .wbe   (wbe_m),
      .waddr (waddr_m),
      .wdata (wdata_m),
      .re    (bk_re[b]),
      .raddr (bus.addr_rd),
      .rdata (bk_rdata[b])
    );
  end

  // Stage-1 side info only moves on a read, so the output mux holds between pulses.
  logic [BANK_W-1:0]       rd_bank_q, rd_bank_d;
  logic                    coll_q, coll_d;
  logic [BE_W-1:0]         cbe_q, cbe_d;
  logic [DW-1:0]           cdin_q, cdin_d;
  logic [RD_LATENCY:1]     vld_pipe_q, vld_pipe_d;

  always_comb begin
    rd_bank_d = rd_bank_q;
    coll_d    = coll_q;
    cbe_d     = cbe_q;
    cdin_d    = cdin_q;
    if (rd_acc) begin
      rd_bank_d = rb_e;
      coll_d    = coll;
      cbe_d     = bus.wr_be;
      cdin_d    = bus.din;
    end
    vld_pipe_d[1] = rd_acc;
    for (int i = 2; i <= RD_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_q  <= '0;
      coll_q     <= 1'b0;
      cbe_q      <= '0;
      cdin_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      rd_bank_q  <= rd_bank_d;
      coll_q     <= coll_d;
      cbe_q      <= cbe_d;
      cdin_q     <= cdin_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  logic [DW-1:0] s1_data;

  always_comb begin
    s1_data = bk_rdata[rd_bank_q];
    if ((RDW_MODE == 1) && coll_q) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cbe_q[i]) s1_data[8*i +: 8] = cdin_q[8*i +: 8];
      end
    end
  end

  assign bus.dout_valid = vld_pipe_q[RD_LATENCY];

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DW-1:0] dout2_q, dout2_d;

    always_comb dout2_d = vld_pipe_q[1] ? s1_data : dout2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) dout2_q <= '0;
      else        dout2_q <= dout2_d;
    end

    assign bus.dout = dout2_q;
  end else begin : g_lat1
    assign bus.dout = s1_data;
  end
endmodule

// File: tb/tb_bram_sdp_banked.sv
// Random and directed bench for bram_sdp_banked; two instances (lat1/read-first, lat2/write-first) share stimulus.
module tb_bram_sdp_banked;
  localparam int DW = 32, AW = 4, NB = 4, BW = 2, DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_sdp_banked_if #(.DATA_BIT_WIDTH(DW), .DEPTH_BIT_WIDTH(AW), .BANK_W(BW)) bus0 ();
  bram_sdp_banked_if #(.DATA_BIT_WIDTH(DW), .DEPTH_BIT_WIDTH(AW), .BANK_W(BW)) bus1 ();

  bram_sdp_banked #(.DATA_BIT_WIDTH(DW), .DEPTH_BIT_WIDTH(AW), .NUM_BANKS(NB),
    .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bram_sdp_banked #(.DATA_BIT_WIDTH(DW), .DEPTH_BIT_WIDTH(AW), .NUM_BANKS(NB),
    .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb [2][$];
  logic [DW-1:0] mem_m [NB][DEPTH];
  logic [DW-1:0] last_m [2];
  int unsigned   cyc = 0;
  int            busy_left = 0;
  bit            started = 0;
  int            n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic mon_port(int p, logic v, logic [DW-1:0] d);
    exp_t e;
    bit ev;
    ev = (sb[p].size() > 0) && (sb[p][0].cyc == cyc);
    check(p == 0 ? "dout_valid0" : "dout_valid1", {31'b0, v}, {31'b0, ev});
    if (ev) begin
      e = sb[p].pop_front();
      check(p == 0 ? "dout0" : "dout1", d, e.data);
      last_m[p] = e.data;
    end else begin
      check(p == 0 ? "dout_hold0" : "dout_hold1", d, last_m[p]);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        sb[p].delete();
        last_m[p] = '0;
      end
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DEPTH; a++) mem_m[b][a] = '0;
      busy_left = DEPTH;
      started   = 1;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    if (started) begin
      check("init_busy0", {31'b0, bus0.init_busy}, {31'b0, busy_left > 0});
      check("init_busy1", {31'b0, bus1.init_busy}, {31'b0, busy_left > 0});
      mon_port(0, bus0.dout_valid, bus0.dout);
      mon_port(1, bus1.dout_valid, bus1.dout);
    end
  end

  task automatic set_bus(bit cs, bit we, int wb, int wa, logic [3:0] be, logic [DW-1:0] d,
                         bit re, int rb, int ra);
    bus0.cs = cs; bus0.wr_en = we; bus0.wr_bank = BW'(wb); bus0.addr_wr = AW'(wa);
    bus0.wr_be = be; bus0.din = d; bus0.rd_en = re; bus0.rd_bank = BW'(rb); bus0.addr_rd = AW'(ra);
    bus1.cs = cs; bus1.wr_en = we; bus1.wr_bank = BW'(wb); bus1.addr_wr = AW'(wa);
    bus1.wr_be = be; bus1.din = d; bus1.rd_en = re; bus1.rd_bank = BW'(rb); bus1.addr_rd = AW'(ra);
  endtask

  task automatic drive(bit cs, bit we, int wb, int wa, logic [3:0] be, logic [DW-1:0] d,
                       bit re, int rb, int ra);
    logic [DW-1:0] old, m;
    @(negedge clk);
    set_bus(cs, we, wb, wa, be, d, re, rb, ra);
    if (rst_n && busy_left == 0 && cs) begin
      if (re) begin
        old = mem_m[rb][ra];
        m   = (we && wb == rb && wa == ra) ? merge(old, d, be) : old;
        sb[0].push_back('{cyc + 1, old});
        sb[1].push_back('{cyc + 2, m});
      end
      if (we) mem_m[wb][wa] = merge(mem_m[wb][wa], d, be);
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 4'h0, '0, 0, 0, 0);
  endtask

  task automatic wr(int b, int a, logic [3:0] be, logic [DW-1:0] d);
    drive(1, 1, b, a, be, d, 0, 0, 0);
  endtask

  task automatic rd(int b, int a);
    drive(1, 0, 0, 0, 4'h0, '0, 1, b, a);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst_n = 1'b0;
    set_bus(0, 0, 0, 0, 4'h0, '0, 0, 0, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requests issued during the sweep must be dropped; the bound guards against a stuck init_busy.
  task automatic wait_ready();
    int i;
    for (i = 0; i < 100 && busy_left > 0; i++)
      drive(1, 1, $urandom_range(0, NB-1), $urandom_range(0, DEPTH-1), 4'hF, $urandom,
            1, $urandom_range(0, NB-1), $urandom_range(0, DEPTH-1));
    check("ready_timeout", {31'b0, busy_left > 0}, 32'd0);
  endtask

  initial begin
    set_bus(0, 0, 0, 0, 4'h0, '0, 0, 0, 0);
    do_reset(2);
    wait_ready();

    // Pre-fill with a marker, reset, and confirm the sweep cleared everything.
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) wr(b, a, 4'hF, 32'hDEADBEEF);
    rd(3, 15);
    rd(0, 0);
    idle();
    do_reset(1);
    wait_ready();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) rd(b, a);

    // Byte enables.
    wr(2, 5, 4'hF, 32'h11223344);
    wr(2, 5, 4'b0101, 32'hAABBCCDD);
    rd(2, 5);
    wr(2, 6, 4'h0, 32'hFFFFFFFF);
    rd(2, 6);

    // Collisions and non-colliding neighbours.
    wr(1, 7, 4'hF, 32'h0);
    drive(1, 1, 1, 7, 4'b0011, 32'h0000FFFF, 1, 1, 7);
    drive(1, 1, 0, 7, 4'hF, 32'h12345678, 1, 1, 7);
    drive(1, 1, 1, 6, 4'hF, 32'h87654321, 1, 1, 7);
    rd(0, 7);

    // Streaming reads at full rate.
    for (int a = 0; a < DEPTH; a++) wr(3, a, 4'hF, $urandom);
    for (int a = 0; a < DEPTH; a++) rd(3, a);
    idle();

    // Chip-select gating.
    drive(0, 1, 2, 5, 4'hF, 32'h55, 0, 0, 0);
    drive(0, 0, 0, 0, 4'h0, '0, 1, 2, 5);
    idle();
    rd(2, 5);

    // Random traffic with a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 3);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, NB-1), wa,
            4'($urandom), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, NB-1), ra);
    end

    // Reset at sweep counter 5, then a full sweep again.
    do_reset(1);
    repeat (5) idle();
    do_reset(1);
    wait_ready();
    wr(1, 3, 4'hF, 32'hCAFEF00D);
    rd(1, 3);
    idle();

    // Reset with a read in flight (still in the latency-2 pipeline).
    rd(1, 3);
    do_reset(1);
    wait_ready();
    rd(1, 3);
    rd(2, 9);

    repeat (5) idle();
    check("sb_empty0", sb[0].size(), 32'd0);
    check("sb_empty1", sb[1].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
